// File: rtl/flush_sink_pkg.sv
// Shared cache definitions for the flush path: walk FSM states and the
// flush opcode encoding carried in the request's "all" bit.
package flush_sink_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_e;

  localparam logic FLUSH_LINE = 1'b0;
  localparam logic FLUSH_ALL  = 1'b1;

endpackage

// File: rtl/flush_fifo.sv
// Small circular FIFO with registered storage; the head is read straight
// from the storage registers, so data appears the cycle after it is written.
module flush_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;

  assign in_ready_o  = (count_q != FULL_CNT);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an empty count makes its contents irrelevant.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/flush_sink.sv
// Flush request sink: buffers line/whole-cache flushes and turns each into
// directory requests, walking every set for a whole-cache flush.
module flush_sink
  import flush_sink_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int SET_BITS    = 10,
  parameter int DEPTH       = 2,
  parameter int TAG_BITS    = ADDR_W - OFFSET_BITS - SET_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_x_valid,
  output logic                io_x_ready,
  input  logic [ADDR_W-1:0]   io_x_bits_address,
  input  logic                io_x_bits_all,
  output logic                io_req_valid,
  input  logic                io_req_ready,
  output logic [TAG_BITS-1:0] io_req_bits_tag,
  output logic [SET_BITS-1:0] io_req_bits_set,
  output logic                io_req_bits_all,
  output logic                io_busy
);

  localparam int ENTRY_W = 1 + TAG_BITS + SET_BITS;

  typedef struct packed {
    logic                all;
    logic [TAG_BITS-1:0] tag;
    logic [SET_BITS-1:0] set;
  } entry_t;

  entry_t              in_entry, head;
  logic                head_valid, pop, fire;
  walk_state_e         state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                unused_offset;

  // Decode at enqueue so the FIFO only carries the fields the directory needs.
  assign in_entry.all  = io_x_bits_all;
  assign in_entry.tag  = io_x_bits_address[ADDR_W-1 -: TAG_BITS];
  assign in_entry.set  = io_x_bits_address[OFFSET_BITS +: SET_BITS];
  assign unused_offset = ^io_x_bits_address[OFFSET_BITS-1:0];

  flush_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (io_x_valid),
    .in_ready_o  (io_x_ready),
    .in_data_i   (in_entry),
    .out_valid_o (head_valid),
    .out_ready_i (pop),
    .out_data_o  (head)
  );

  assign fire = io_req_valid && io_req_ready;

  // NOTE: every combinational output gets a default first so no path leaves a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pop             = 1'b0;
    io_req_valid    = 1'b0;
    io_req_bits_tag = '0;
    io_req_bits_set = '0;
    io_req_bits_all = FLUSH_LINE;
    io_busy         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        io_req_valid = head_valid;
        if (head.all == FLUSH_ALL) begin
          io_req_bits_all = FLUSH_ALL;
          if (fire) begin
            if (SET_BITS == 0) begin
              pop = 1'b1;
            end else begin
              cnt_d   = SET_BITS'(1);
              state_d = ST_WALK;
            end
          end
        end else begin
          io_req_bits_tag = head.tag;
          io_req_bits_set = head.set;
          pop             = fire;
        end
      end
      ST_WALK: begin
        io_req_valid    = 1'b1;
        io_req_bits_set = cnt_q;
        io_req_bits_all = FLUSH_ALL;
        io_busy         = 1'b1;
        if (fire) begin
          if (cnt_q == '1) begin
            pop     = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + SET_BITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_flush_sink.sv
// Directed bench for flush_sink: default-parameter instance for line traffic
// and back-pressure, SET_BITS=3 instance for whole-cache walks and reset.
module tb_flush_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance A: defaults (ADDR_W=32, SET_BITS=10, TAG=16, DEPTH=2)
  logic        rst_a, xa_valid, xa_ready, xa_all, ra_valid, ra_ready, ra_all, a_busy;
  logic [31:0] xa_addr;
  logic [15:0] ra_tag;
  logic [9:0]  ra_set;

  flush_sink u_a (
    .clock(clk), .reset(rst_a),
    .io_x_valid(xa_valid), .io_x_ready(xa_ready),
    .io_x_bits_address(xa_addr), .io_x_bits_all(xa_all),
    .io_req_valid(ra_valid), .io_req_ready(ra_ready),
    .io_req_bits_tag(ra_tag), .io_req_bits_set(ra_set),
    .io_req_bits_all(ra_all), .io_busy(a_busy)
  );

  // Instance B: ADDR_W=16, OFFSET=6, SET_BITS=3 -> TAG=7, DEPTH=2
  logic        rst_b, xb_valid, xb_ready, xb_all, rb_valid, rb_ready, rb_all, b_busy;
  logic [15:0] xb_addr;
  logic [6:0]  rb_tag;
  logic [2:0]  rb_set;

  flush_sink #(.ADDR_W(16), .OFFSET_BITS(6), .SET_BITS(3), .DEPTH(2)) u_b (
    .clock(clk), .reset(rst_b),
    .io_x_valid(xb_valid), .io_x_ready(xb_ready),
    .io_x_bits_address(xb_addr), .io_x_bits_all(xb_all),
    .io_req_valid(rb_valid), .io_req_ready(rb_ready),
    .io_req_bits_tag(rb_tag), .io_req_bits_set(rb_set),
    .io_req_bits_all(rb_all), .io_busy(b_busy)
  );

  typedef struct {
    logic        xv;
    logic [31:0] addr;
    logic        all;
    logic        rr;
    logic        e_xr;
    logic        e_rv;
    logic [15:0] e_tag;
    logic [9:0]  e_set;
    logic        e_all;
    logic        e_busy;
  } vec_t;

  vec_t vecs [14];

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step_a(input logic xv, input logic [31:0] addr, input logic all, input logic rr);
    @(negedge clk);
    xa_valid = xv; xa_addr = addr; xa_all = all; ra_ready = rr;
    #1;
  endtask

  task automatic step_b(input logic xv, input logic [15:0] addr, input logic all, input logic rr);
    @(negedge clk);
    xb_valid = xv; xb_addr = addr; xb_all = all; rb_ready = rr;
    #1;
  endtask

  task automatic check_walk_b(input string name, input logic [2:0] set, input logic busy);
    check({name, "_valid"}, 32'(rb_valid), 32'd1);
    check({name, "_set"},   32'(rb_set),   32'(set));
    check({name, "_tag"},   32'(rb_tag),   32'd0);
    check({name, "_all"},   32'(rb_all),   32'd1);
    check({name, "_busy"},  32'(b_busy),   32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fires;
    logic [2:0] exp_set;

    rst_a = 1'b1; rst_b = 1'b1;
    xa_valid = 1'b0; xa_addr = '0; xa_all = 1'b0; ra_ready = 1'b0;
    xb_valid = 1'b0; xb_addr = '0; xb_all = 1'b0; rb_ready = 1'b0;

    vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h8001_2340, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8001, 10'h08D, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hABCD_0040, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 10'h159, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_FFC0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 10'h159, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_FFC0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 10'h159, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_FFC0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD, 10'h001, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 10'h001, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h00C0_0080, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 10'h3FF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00C0, 10'h002, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00C0, 10'h002, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 10'h000, 1'b0, 1'b0};

    // Reset state
    @(negedge clk); #1;
    check("rst_a_xready", 32'(xa_ready), 32'd1);
    check("rst_a_rvalid", 32'(ra_valid), 32'd0);
    check("rst_a_busy",   32'(a_busy),   32'd0);
    check("rst_b_xready", 32'(xb_ready), 32'd1);
    check("rst_b_rvalid", 32'(rb_valid), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Line traffic, back-pressure and simultaneous enq/deq on instance A
    for (int i = 0; i < 14; i++) begin
      step_a(vecs[i].xv, vecs[i].addr, vecs[i].all, vecs[i].rr);
      check($sformatf("vec%0d_xready", i), 32'(xa_ready), 32'(vecs[i].e_xr));
      check($sformatf("vec%0d_rvalid", i), 32'(ra_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d_busy", i),   32'(a_busy),   32'(vecs[i].e_busy));
      if (vecs[i].e_rv) begin
        check($sformatf("vec%0d_tag", i), 32'(ra_tag), 32'(vecs[i].e_tag));
        check($sformatf("vec%0d_set", i), 32'(ra_set), 32'(vecs[i].e_set));
        check($sformatf("vec%0d_all", i), 32'(ra_all), 32'(vecs[i].e_all));
      end
    end

    // Full walk with ready held high: sets 0..7, busy from the second set on
    step_b(1'b1, 16'h0000, 1'b1, 1'b1);
    check("walk_enq_rvalid", 32'(rb_valid), 32'd0);
    for (int s = 0; s < 8; s++) begin
      step_b(1'b0, 16'h0000, 1'b0, 1'b1);
      check_walk_b($sformatf("walk_s%0d", s), 3'(s), s != 0);
    end
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("walk_end_rvalid", 32'(rb_valid), 32'd0);
    check("walk_end_busy",   32'(b_busy),   32'd0);

    // Walk with ready toggling, starting stalled
    step_b(1'b1, 16'h0000, 1'b1, 1'b0);
    fires = 0;
    exp_set = 3'd0;
    for (int cyc = 0; cyc < 40 && fires < 8; cyc++) begin
      step_b(1'b0, 16'h0000, 1'b0, cyc[0]);
      check_walk_b($sformatf("tog_c%0d", cyc), exp_set, exp_set != 3'd0 || fires != 0);
      if (cyc[0]) begin
        fires++;
        exp_set = exp_set + 3'd1;
      end
    end
    check("tog_fires", 32'(fires), 32'd8);
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("tog_end_rvalid", 32'(rb_valid), 32'd0);

    // Line request queued behind a walk follows the last set immediately
    step_b(1'b1, 16'h0000, 1'b1, 1'b1);
    step_b(1'b1, 16'hB2C0, 1'b0, 1'b1);
    check_walk_b("q_s0", 3'd0, 1'b0);
    for (int s = 1; s < 8; s++) begin
      step_b(1'b0, 16'h0000, 1'b0, 1'b1);
      check_walk_b($sformatf("q_s%0d", s), 3'(s), 1'b1);
    end
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("q_line_rvalid", 32'(rb_valid), 32'd1);
    check("q_line_tag",    32'(rb_tag),   32'h59);
    check("q_line_set",    32'(rb_set),   32'd3);
    check("q_line_all",    32'(rb_all),   32'd0);
    check("q_line_busy",   32'(b_busy),   32'd0);
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("q_end_rvalid", 32'(rb_valid), 32'd0);

    // Reset in the middle of a walk with a line entry queued
    step_b(1'b1, 16'h0000, 1'b1, 1'b1);
    step_b(1'b1, 16'h1240, 1'b0, 1'b1);
    for (int s = 1; s < 5; s++) step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check_walk_b("rw_s4", 3'd4, 1'b1);
    rst_b = 1'b1;
    #1;
    check("rw_rst_rvalid", 32'(rb_valid), 32'd0);
    check("rw_rst_busy",   32'(b_busy),   32'd0);
    check("rw_rst_xready", 32'(xb_ready), 32'd1);
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step_b(1'b0, 16'h0000, 1'b0, 1'b1);
      check($sformatf("rw_quiet%0d", c), 32'(rb_valid), 32'd0);
    end
    step_b(1'b1, 16'h1240, 1'b0, 1'b1);
    check("rw_new_enq_rvalid", 32'(rb_valid), 32'd0);
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("rw_new_rvalid", 32'(rb_valid), 32'd1);
    check("rw_new_tag",    32'(rb_tag),   32'h09);
    check("rw_new_set",    32'(rb_set),   32'd1);
    check("rw_new_all",    32'(rb_all),   32'd0);
    step_b(1'b0, 16'h0000, 1'b0, 1'b1);
    check("rw_end_rvalid", 32'(rb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
